score_counter: RTL and testbench

Front-end scoring stage of the ScoreKeeper datapath. It takes raw player push-buttons, synchronizes and debounces them, and keeps a saturating 5-bit score. It also detects the win condition. Its `score` output drives the 5-bit input of the BCD converter directly, so it is always held in 0..31.

---
 rtl/score_counter_if.sv | 26 ++
 rtl/score_counter.sv | 143 ++++++++++++++
 tb/tb_score_counter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/score_counter_if.sv
// score_counter_if: groups the player-facing signals of the score counter.
//   inc_btn   raw asynchronous "add point" button
//   dec_btn   raw asynchronous "remove point" button
//   clr       synchronous level "new game" request
//   score     current score, 0..31
//   game_over high while the game is won
//   step      one-cycle pulse on every score change
// master drives the buttons and clr and observes the score; slave is the counter.
interface score_counter_if;
  logic       inc_btn;
  logic       dec_btn;
  logic       clr;
  logic [4:0] score;
  logic       game_over;
  logic       step;

  modport master (
    output inc_btn, dec_btn, clr,
    input  score, game_over, step
  );

  modport slave (
    input  inc_btn, dec_btn, clr,
    output score, game_over, step
  );
endinterface

// File: rtl/score_counter.sv
// score_debounce: two-flop synchronizer, level debouncer and rising-edge
// press detector for one raw push-button.
//   clk      clock
//   rst      synchronous active-high reset
//   btn_raw  raw asynchronous button level
//   press    one-cycle pulse on each accepted low-to-high transition
module score_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);
  // cnt only ever holds 0..DEBOUNCE_CYCLES-1; it clears on the edge it would
  // have reached DEBOUNCE_CYCLES.
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          deb;
  logic          deb_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      deb   <= 1'b0;
      deb_q <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= btn_raw;
      s2    <= s1;
      deb_q <= deb;
      if (s2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = deb & ~deb_q;
endmodule

// score_counter: debounces the two player buttons and keeps a 5-bit
// saturating score with a win condition.
//   clk   clock, all updates on the rising edge
//   rst   synchronous active-high reset
//   bus   score_counter_if.slave: inc_btn, dec_btn, clr in; score,
//         game_over, step out (all outputs registered)
//
// state | meaning
// PLAY  | game in progress, presses change the score
// WON   | score reached WIN_SCORE, presses ignored until clr/rst
module score_counter #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned WIN_SCORE       = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  score_counter_if.slave       bus
);
  localparam logic [4:0] WIN_VAL   = 5'(WIN_SCORE);
  localparam logic [4:0] SCORE_MAX = 5'd31;

  typedef enum logic {
    PLAY = 1'b0,
    WON  = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] score_r;
  logic [4:0] score_nxt;
  logic       step_r;
  logic       step_nxt;
  logic       inc_press;
  logic       dec_press;

  score_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_inc (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.inc_btn),
    .press   (inc_press)
  );

  score_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dec (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.dec_btn),
    .press   (dec_press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= PLAY;
      score_r <= '0;
      step_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      score_r <= score_nxt;
      step_r  <= step_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    score_nxt = score_r;
    step_nxt  = 1'b0;
    if (bus.clr) begin
      // clr wins over any press arriving in the same cycle.
      score_nxt = '0;
      state_nxt = PLAY;
      step_nxt  = (score_r != '0);
    end else if (state == PLAY) begin
      // Simultaneous presses cancel and fall through with no change.
      if (inc_press && !dec_press) begin
        if (score_r != SCORE_MAX) begin
          score_nxt = score_r + 5'd1;
          step_nxt  = 1'b1;
          if (score_nxt == WIN_VAL) begin
            state_nxt = WON;
          end
        end
      end else if (dec_press && !inc_press) begin
        if (score_r != '0) begin
          score_nxt = score_r - 5'd1;
          step_nxt  = 1'b1;
        end
      end
    end
  end

  assign bus.score     = score_r;
  assign bus.step      = step_r;
  assign bus.game_over = (state == WON);
endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: directed scenarios plus a randomized run of
// score_counter (DEBOUNCE_CYCLES=4, WIN_SCORE=5), compared every cycle
// against a behavioural model working on input history.
module tb_score_counter;
  localparam int DEB = 4;
  localparam int WIN = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  score_counter_if bus ();

  score_counter #(
    .DEBOUNCE_CYCLES (DEB),
    .WIN_SCORE       (WIN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total    = 0;
  int bad      = 0;
  int step_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model. A button level is accepted once the last DEB
  // synchronized samples (since reset) all disagree with the accepted level;
  // a press is an accepted level that went high on the previous edge.
  int m_score = 0;
  bit m_won   = 0;
  bit m_step  = 0;
  bit m_s1   [2];
  bit m_s2   [2];
  bit m_acc  [2];
  bit m_accq [2];
  bit hist   [2][DEB];
  int hlen   [2];

  always @(posedge clk) begin : model
    bit raw [2];
    bit pr  [2];
    bit all_diff;
    raw[0] = bus.inc_btn;
    raw[1] = bus.dec_btn;
    if (rst) begin
      m_score = 0;
      m_won   = 0;
      m_step  = 0;
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_acc[b] = 0; m_accq[b] = 0; hlen[b] = 0;
      end
    end else begin
      for (int b = 0; b < 2; b++) pr[b] = m_acc[b] && !m_accq[b];
      m_step = 0;
      if (bus.clr) begin
        m_step  = (m_score != 0);
        m_score = 0;
        m_won   = 0;
      end else if (!m_won && pr[0] && !pr[1] && m_score < 31) begin
        m_score = m_score + 1;
        m_step  = 1;
        if (m_score == WIN) m_won = 1;
      end else if (!m_won && pr[1] && !pr[0] && m_score > 0) begin
        m_score = m_score - 1;
        m_step  = 1;
      end
      for (int b = 0; b < 2; b++) begin
        m_accq[b] = m_acc[b];
        for (int i = DEB - 1; i > 0; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = m_s2[b];
        if (hlen[b] < DEB) hlen[b]++;
        all_diff = (hlen[b] == DEB);
        for (int i = 0; i < DEB; i++) if (hist[b][i] == m_acc[b]) all_diff = 0;
        if (all_diff) m_acc[b] = !m_acc[b];
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
    end
  end

  always @(negedge clk) begin
    chk("m_score", 32'(bus.score), 32'(m_score));
    chk("m_game_over", 32'(bus.game_over), 32'(m_won));
    chk("m_step", 32'(bus.step), 32'(m_step));
  end

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      if (bus.step === 1'b1) step_cnt++;
    end
  endtask

  task automatic press(input bit inc, input bit dec);
    bus.inc_btn = inc;
    bus.dec_btn = dec;
    run(8);
    bus.inc_btn = 1'b0;
    bus.dec_btn = 1'b0;
    run(10);
  endtask

  int rem_inc = 0;
  int rem_dec = 0;

  initial begin
    bus.inc_btn = 1'b0;
    bus.dec_btn = 1'b0;
    bus.clr     = 1'b0;
    rst         = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_score", 32'(bus.score), 0);
    chk("rst_game_over", 32'(bus.game_over), 0);
    chk("rst_step", 32'(bus.step), 0);

    // held press: one increment at edge 7
    step_cnt = 0;
    bus.inc_btn = 1'b1;
    run(6);
    chk("hold_edge6_score", 32'(bus.score), 0);
    run(1);
    chk("hold_edge7_score", 32'(bus.score), 1);
    chk("hold_edge7_step", 32'(bus.step), 1);
    run(1);
    chk("hold_edge8_step", 32'(bus.step), 0);
    run(12);
    chk("hold_end_score", 32'(bus.score), 1);
    chk("hold_steps", 32'(step_cnt), 1);
    bus.inc_btn = 1'b0;
    run(10);
    bus.clr = 1'b1;
    run(1);
    bus.clr = 1'b0;
    run(1);

    // glitch rejection
    step_cnt = 0;
    bus.inc_btn = 1'b1; run(3); bus.inc_btn = 1'b0; run(10);
    bus.dec_btn = 1'b1; run(3); bus.dec_btn = 1'b0; run(10);
    chk("glitch_score", 32'(bus.score), 0);
    chk("glitch_steps", 32'(step_cnt), 0);

    // floor
    step_cnt = 0;
    press(0, 1);
    chk("floor_score", 32'(bus.score), 0);
    chk("floor_steps", 32'(step_cnt), 0);
    press(1, 0);
    chk("floor_inc_score", 32'(bus.score), 1);
    chk("floor_inc_steps", 32'(step_cnt), 1);
    step_cnt = 0;
    press(0, 1);
    chk("floor_dec_score", 32'(bus.score), 0);
    chk("floor_dec_steps", 32'(step_cnt), 1);

    // win and clear
    step_cnt = 0;
    repeat (5) press(1, 0);
    chk("win_score", 32'(bus.score), 5);
    chk("win_game_over", 32'(bus.game_over), 1);
    chk("win_steps", 32'(step_cnt), 5);
    step_cnt = 0;
    repeat (2) press(1, 0);
    chk("won_hold_score", 32'(bus.score), 5);
    chk("won_hold_steps", 32'(step_cnt), 0);
    bus.clr = 1'b1;
    run(1);
    bus.clr = 1'b0;
    chk("clr_score", 32'(bus.score), 0);
    chk("clr_game_over", 32'(bus.game_over), 0);
    chk("clr_step", 32'(bus.step), 1);

    // simultaneous presses cancel
    press(1, 0);
    press(1, 0);
    chk("simul_pre_score", 32'(bus.score), 2);
    step_cnt = 0;
    press(1, 1);
    chk("simul_score", 32'(bus.score), 2);
    chk("simul_steps", 32'(step_cnt), 0);

    // reset mid-debounce
    press(1, 0);
    chk("rstmid_pre_score", 32'(bus.score), 3);
    bus.inc_btn = 1'b1;
    run(4);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    chk("rstmid_score", 32'(bus.score), 0);
    chk("rstmid_game_over", 32'(bus.game_over), 0);
    run(6);
    chk("rstmid_edge6_score", 32'(bus.score), 0);
    run(1);
    chk("rstmid_edge7_score", 32'(bus.score), 1);
    bus.inc_btn = 1'b0;
    run(10);

    // randomized run, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      if (rem_inc == 0) begin
        bus.inc_btn = 1'($urandom_range(0, 1));
        rem_inc = $urandom_range(1, 10);
      end
      if (rem_dec == 0) begin
        bus.dec_btn = 1'($urandom_range(0, 1));
        rem_dec = $urandom_range(1, 10);
      end
      rem_inc--;
      rem_dec--;
      bus.clr = ($urandom_range(0, 39) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    bus.inc_btn = 1'b0;
    bus.dec_btn = 1'b0;
    bus.clr     = 1'b0;
    rst         = 1'b0;
    run(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
